// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition codes, flag bit map and IT sequencer states
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_Q = 4;

  localparam int FW_CV = 0;
  localparam int FW_NZ = 1;
  localparam int FW_Q  = 2;

  typedef enum logic {IT_IDLE, IT_ACTIVE} it_state_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition-code evaluator, shared with branch-predict checker
module cond_eval
  import cond_pkg::*;
#(
  parameter int COND_WIDTH  = 4,
  parameter int FLAGS_WIDTH = 5
) (
  input  logic [COND_WIDTH-1:0]  cond,
  input  logic [FLAGS_WIDTH-1:0] flags,
  output logic                   pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flags_unit.sv
// rtl/cond_flags_unit.sv - architectural flags register, sticky Q and IT-block sequencer
module cond_flags_unit
  import cond_pkg::*;
#(
  parameter int FLAGS_WIDTH = 5,
  parameter int COND_WIDTH  = 4,
  parameter int MAX_IT_LEN  = 4,
  parameter int LEN_W       = $clog2(MAX_IT_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [COND_WIDTH-1:0]  cond,
  input  logic [2:0]             flags_write,
  input  logic [FLAGS_WIDTH-1:0] alu_flags,
  input  logic                   q_clear,
  input  logic                   it_start,
  input  logic [COND_WIDTH-1:0]  it_cond,
  input  logic [LEN_W-1:0]       it_len,
  input  logic [MAX_IT_LEN-1:0]  it_pattern,
  output logic                   cond_ex,
  output logic [FLAGS_WIDTH-1:0] flags,
  output logic                   in_it,
  output logic [LEN_W-1:0]       it_remaining,
  output logic                   it_err
);

  it_state_t               state_q, state_d;
  logic [FLAGS_WIDTH-1:0]  flags_q, flags_d;
  logic [COND_WIDTH-1:0]   it_cond_q, it_cond_d;
  logic [LEN_W-1:0]        it_len_q, it_len_d;
  logic [MAX_IT_LEN-1:0]   it_pattern_q, it_pattern_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic                    err_q, err_d;

  logic                    advance;
  logic [LEN_W-1:0]        slot;
  logic [MAX_IT_LEN-1:0]   pattern_shift;
  logic [COND_WIDTH-1:0]   eff_cond;
  logic                    commit;
  logic                    len_ok;

  assign advance       = instr_valid & ~stall & ~flush;
  assign slot          = it_len_q - rem_q;
  assign pattern_shift = it_pattern_q >> slot;
  assign len_ok        = (it_len != '0) && (it_len <= LEN_W'(MAX_IT_LEN));

  // Else slots flip the condition LSB, which inverts every ARM code pair.
  always_comb begin
    eff_cond = cond;
    if (state_q == IT_ACTIVE)
      eff_cond = pattern_shift[0] ? it_cond_q : {it_cond_q[COND_WIDTH-1:1], ~it_cond_q[0]};
  end

  cond_eval #(.COND_WIDTH(COND_WIDTH), .FLAGS_WIDTH(FLAGS_WIDTH)) u_eval (
    .cond  (eff_cond),
    .flags (flags_q),
    .pass  (cond_ex)
  );

  // An IT request inside an active block executes as an ordinary instruction.
  assign commit = advance & cond_ex & ~(it_start & (state_q == IT_IDLE));

  always_comb begin
    flags_d = flags_q;
    if (commit && flags_write[FW_NZ]) begin
      flags_d[FLAG_N] = alu_flags[FLAG_N];
      flags_d[FLAG_Z] = alu_flags[FLAG_Z];
    end
    if (commit && flags_write[FW_CV]) begin
      flags_d[FLAG_C] = alu_flags[FLAG_C];
      flags_d[FLAG_V] = alu_flags[FLAG_V];
    end
    flags_d[FLAG_Q] = ((advance & q_clear) ? 1'b0 : flags_q[FLAG_Q])
                      | (commit & flags_write[FW_Q] & alu_flags[FLAG_Q]);
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    it_cond_d    = it_cond_q;
    it_len_d     = it_len_q;
    it_pattern_d = it_pattern_q;
    err_d        = 1'b0;
    if (flush) begin
      state_d = IT_IDLE;
      rem_d   = '0;
    end else if (advance) begin
      case (state_q)
        IT_IDLE: begin
          if (it_start) begin
            if (len_ok) begin
              state_d      = IT_ACTIVE;
              rem_d        = it_len;
              it_cond_d    = it_cond;
              it_len_d     = it_len;
              it_pattern_d = it_pattern;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        IT_ACTIVE: begin
          err_d = it_start;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1))
            state_d = IT_IDLE;
        end
        default: state_d = IT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IT_IDLE;
      flags_q      <= '0;
      it_cond_q    <= '0;
      it_len_q     <= '0;
      it_pattern_q <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      it_cond_q    <= it_cond_d;
      it_len_q     <= it_len_d;
      it_pattern_q <= it_pattern_d;
      rem_q        <= rem_d;
      err_q        <= err_d;
    end
  end

  assign flags        = flags_q;
  assign in_it        = (state_q == IT_ACTIVE);
  assign it_remaining = rem_q;
  assign it_err       = err_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// tb/tb_cond_flags_unit.sv - scoreboard bench for cond_flags_unit with directed vectors
module tb_cond_flags_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid, stall, flush, q_clear, it_start;
  logic [3:0] cond, it_cond, it_pattern;
  logic [2:0] flags_write, it_len, it_remaining;
  logic [4:0] alu_flags, flags;
  logic       cond_ex, in_it, it_err;

  cond_flags_unit #(.FLAGS_WIDTH(5), .COND_WIDTH(4), .MAX_IT_LEN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .flush        (flush),
    .cond         (cond),
    .flags_write  (flags_write),
    .alu_flags    (alu_flags),
    .q_clear      (q_clear),
    .it_start     (it_start),
    .it_cond      (it_cond),
    .it_len       (it_len),
    .it_pattern   (it_pattern),
    .cond_ex      (cond_ex),
    .flags        (flags),
    .in_it        (in_it),
    .it_remaining (it_remaining),
    .it_err       (it_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mask bits: 0 cond_ex, 1 flags, 2 in_it, 3 it_remaining, 4 it_err
  typedef struct {
    string      name;
    int         cyc;
    logic [4:0] mask;
    logic       ce;
    logic [4:0] fl;
    logic       ii;
    logic [2:0] rem;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string n, input logic [4:0] m, input logic ce, input logic [4:0] fl,
                      input logic ii, input logic [2:0] rem, input logic err);
    exp_t e;
    e.name = n; e.cyc = cyc; e.mask = m; e.ce = ce; e.fl = fl; e.ii = ii; e.rem = rem; e.err = err;
    sb.push_back(e);
  endtask

  task automatic exp_ce(input string n, input logic ce);
    push(n, 5'b00001, ce, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic exp_fl(input string n, input logic [4:0] fl);
    push(n, 5'b00010, 1'b0, fl, 1'b0, '0, 1'b0);
  endtask

  task automatic exp_it(input string n, input logic ii, input logic [2:0] rem, input logic err);
    push(n, 5'b11100, 1'b0, '0, ii, rem, err);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        tests++; fails++;
        $display("FAIL %s: expectation not checked in its cycle", e.name);
      end else begin
        if (e.mask[0]) begin
          tests++;
          if (cond_ex !== e.ce) begin
            fails++; $display("FAIL %s cond_ex: got %b want %b", e.name, cond_ex, e.ce);
          end
        end
        if (e.mask[1]) begin
          tests++;
          if (flags !== e.fl) begin
            fails++; $display("FAIL %s flags: got %b want %b", e.name, flags, e.fl);
          end
        end
        if (e.mask[2]) begin
          tests++;
          if (in_it !== e.ii) begin
            fails++; $display("FAIL %s in_it: got %b want %b", e.name, in_it, e.ii);
          end
        end
        if (e.mask[3]) begin
          tests++;
          if (it_remaining !== e.rem) begin
            fails++; $display("FAIL %s it_remaining: got %0d want %0d", e.name, it_remaining, e.rem);
          end
        end
        if (e.mask[4]) begin
          tests++;
          if (it_err !== e.err) begin
            fails++; $display("FAIL %s it_err: got %b want %b", e.name, it_err, e.err);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    instr_valid = 0; stall = 0; flush = 0; q_clear = 0; it_start = 0;
    cond = 4'hE; flags_write = 0; alu_flags = 0;
    it_cond = 0; it_len = 0; it_pattern = 0;
  endtask

  task automatic instr(input logic [3:0] c, input logic [2:0] fw, input logic [4:0] alu);
    clr();
    instr_valid = 1; cond = c; flags_write = fw; alu_flags = alu;
  endtask

  task automatic cond_sweep(input string tag, input logic [15:0] table_bits);
    for (int i = 0; i < 16; i++) begin
      tick(); clr(); cond = 4'(i);
      exp_ce($sformatf("%s_cond%0d", tag, i), table_bits[i]);
    end
  endtask

  initial begin
    reset = 1; clr();
    tick(); tick();
    reset = 0; cond = 4'h0;
    exp_ce("rst_eq", 0); exp_fl("rst_flags", 5'b00000); exp_it("rst_it", 0, 0, 0);

    tick(); instr(4'hE, 3'b011, 5'b00100); exp_ce("al_write", 1);
    tick(); clr(); cond = 4'h0; exp_fl("z_set", 5'b00100); exp_ce("eq_after", 1);

    tick(); instr(4'hE, 3'b011, 5'b01000);
    tick(); instr(4'h5, 3'b011, 5'b00110); exp_fl("n_set", 5'b01000); exp_ce("pl_fail", 0);
    tick(); instr(4'hE, 3'b100, 5'b10000); exp_fl("pl_nowrite", 5'b01000);
    tick(); instr(4'hE, 3'b100, 5'b00000); exp_fl("q_set", 5'b11000);
    tick(); instr(4'hE, 3'b100, 5'b10000); q_clear = 1; exp_fl("q_sticky", 5'b11000);
    tick(); instr(4'hE, 3'b000, 5'b00000); q_clear = 1; exp_fl("q_clr_and_set", 5'b11000);
    tick(); instr(4'hE, 3'b011, 5'b00100); exp_fl("q_clr", 5'b01000);

    tick(); instr(4'hE, 3'b011, 5'b00000);
    it_start = 1; it_cond = 4'h0; it_len = 3; it_pattern = 4'b0101;
    exp_fl("z_again", 5'b00100); exp_it("it_pre", 0, 0, 0);
    tick(); instr(4'hF, 3'b000, 5'b00000);
    exp_fl("it_instr_nowrite", 5'b00100); exp_it("it_s0", 1, 3, 0); exp_ce("it_s0", 1);
    tick(); instr(4'h0, 3'b011, 5'b00000); stall = 1;
    exp_it("it_s1_stall", 1, 2, 0); exp_ce("it_s1_stall", 0);
    tick(); instr(4'h0, 3'b011, 5'b00000);
    exp_it("it_s1", 1, 2, 0); exp_ce("it_s1", 0);
    tick(); instr(4'h1, 3'b000, 5'b00000); stall = 1;
    exp_it("it_s2_stall", 1, 1, 0); exp_ce("it_s2_stall", 1); exp_fl("it_s1_nowrite", 5'b00100);
    tick(); instr(4'h1, 3'b000, 5'b00000);
    exp_it("it_s2", 1, 1, 0); exp_ce("it_s2", 1);
    tick(); instr(4'h1, 3'b000, 5'b00000);
    exp_it("it_done", 0, 0, 0); exp_ce("it_own_cond", 0);

    tick(); instr(4'hE, 3'b000, 5'b00000);
    it_start = 1; it_cond = 4'h0; it_len = 4; it_pattern = 4'b1111;
    tick(); instr(4'h1, 3'b000, 5'b00000);
    exp_it("fl_s0", 1, 4, 0); exp_ce("fl_s0", 1);
    tick(); instr(4'h1, 3'b011, 5'b01001); flush = 1;
    exp_it("fl_s1", 1, 3, 0); exp_ce("fl_s1", 1);
    tick(); instr(4'h1, 3'b000, 5'b00000);
    exp_it("fl_after", 0, 0, 0); exp_fl("fl_nowrite", 5'b00100); exp_ce("fl_own_cond", 0);

    tick(); instr(4'hE, 3'b000, 5'b00000); it_start = 1; it_len = 0;
    tick(); clr(); exp_it("len0_err", 0, 0, 1);
    tick(); instr(4'hE, 3'b000, 5'b00000); it_start = 1; it_len = 5;
    exp_it("len0_pulse_end", 0, 0, 0);
    tick(); clr(); exp_it("len5_err", 0, 0, 1);
    tick(); instr(4'hE, 3'b000, 5'b00000);
    it_start = 1; it_cond = 4'hE; it_len = 2; it_pattern = 4'b0011;
    exp_it("len5_pulse_end", 0, 0, 0);
    tick(); instr(4'hE, 3'b000, 5'b00000); it_start = 1; it_len = 2;
    exp_it("nest_s0", 1, 2, 0);
    tick(); clr(); exp_it("nest_err", 1, 1, 1);
    tick(); instr(4'hE, 3'b000, 5'b00000); exp_it("nest_pulse_end", 1, 1, 0);
    tick(); instr(4'hE, 3'b011, 5'b01010); exp_it("nest_done", 0, 0, 0);
    tick(); clr(); exp_fl("nc_set", 5'b01010);

    cond_sweep("nc", 16'h6996);
    tick(); instr(4'hE, 3'b011, 5'b00101);
    tick(); clr(); exp_fl("zv_set", 5'b00101);
    cond_sweep("zv", 16'h6A69);

    tick(); clr();
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL %s: expectation never checked", sb[0].name);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cond_flags_unit.md
Name: cond_flags_unit

Overview:
- Parametrised successor to the pipeline's combinational condition checker. Holds the architectural flags register ({Q,N,Z,C,V}), evaluates 4-bit condition codes and commits ALU flags per write group.
- Adds a sticky saturation flag and an IT-block sequencer that overrides per-instruction conditions for up to MAX_IT_LEN following instructions.
- Sits in the execute stage, between the decoder's condition/flag-write fields and the ALU flag outputs.

Parameters:
- FLAGS_WIDTH, 5, flag vector width; bit map {Q,N,Z,C,V}, bit4..bit0; fixed at 5 for this revision.
- COND_WIDTH, 4, condition code width.
- MAX_IT_LEN, 4, maximum instructions in one IT block (2..8).
- LEN_W, $clog2(MAX_IT_LEN+1), width of the IT length and remaining-count fields.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  execute-stage instruction present
- stall  in  1  hold execute stage; no state change
- flush  in  1  kill execute-stage instruction and abort any IT block
- cond  in  COND_WIDTH  instruction condition (ignored while in IT block)
- flags_write  in  3  [0]=C,V  [1]=N,Z  [2]=Q (sticky OR)
- alu_flags  in  FLAGS_WIDTH  flags produced by ALU
- q_clear  in  1  explicit clear of Q (MSR-style)
- it_start  in  1  current instruction is an IT instruction
- it_cond  in  COND_WIDTH  IT base condition
- it_len  in  LEN_W  IT block length, 1..MAX_IT_LEN
- it_pattern  in  MAX_IT_LEN  bit i: 1=then (it_cond), 0=else (it_cond^1) for slot i
- cond_ex  out  1  effective condition passed (combinational)
- flags  out  FLAGS_WIDTH  registered flags
- in_it  out  1  IT block active
- it_remaining  out  LEN_W  slots left in IT block
- it_err  out  1  one-cycle pulse on an illegal IT request

Behaviour:
- Reset (synchronous, active-high): flags=0, state=IDLE, in_it=0, it_remaining=0, it_err=0. Reset overrides all other inputs in the same cycle.
- advance = instr_valid & ~stall & ~flush.
- Effective condition:
  - IDLE: cond.
  - ACTIVE: slot n = it_len_q - it_remaining. If it_pattern_q[n] is set, use it_cond_q; otherwise use it_cond_q ^ 1.
- cond_ex is combinational from the effective condition and the registered flags.
  - EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL use standard ARM semantics; GE is N==V.
  - 1111 (NV) gives cond_ex=0. No X output for any code.
- Flag commit on the clock edge, only when advance & cond_ex & not an IT instruction:
  - flags_write[1] loads N,Z from alu_flags.
  - flags_write[0] loads C,V from alu_flags.
  - Q_next = (q_clear ? 0 : Q) | (advance & cond_ex & flags_write[2] & alu_flags[4]). q_clear requires advance only, not cond_ex. Clear and set in the same cycle gives Q=1.
- Latency: committed flags are visible on flags and drive cond_ex one cycle later. There is no internal forwarding.
- FSM IDLE:
  - advance & it_start with it_len in 1..MAX_IT_LEN: latch it_cond, it_len, it_pattern; go to ACTIVE; it_remaining=it_len. The IT instruction itself writes no flags.
  - it_len=0 or it_len>MAX_IT_LEN: pulse it_err and stay IDLE.
- FSM ACTIVE:
  - Each advance consumes one slot (executed or not) and decrements it_remaining. When it reaches 0, go to IDLE; in_it=0 in the following cycle.
  - it_start while ACTIVE pulses it_err. The instruction still consumes a slot as a normal instruction, and the IT request is ignored.
- flush: the instruction in that cycle commits no flags and clears nothing. The FSM goes to IDLE and it_remaining to 0 next cycle. flush beats a simultaneous it_start.
- stall: all state is held; cond_ex stays valid combinationally.

Decomposition:
- Shared package `cond_pkg`:
  - cond code constants COND_EQ..COND_NV;
  - flag bit indices FLAG_Q/N/Z/C/V;
  - flags_write bit indices;
  - FSM state enum {IT_IDLE, IT_ACTIVE}.
- Sub-module `cond_eval`: purely combinational (cond, flags) -> pass. It is reused by the branch-predict checker.
- The top level holds the flags register, Q logic and the IT FSM/counter.

Test Plan:
- Reset, then cond=0000 (EQ) with flags=0 -> cond_ex=0. Then an ALU op with flags_write=3'b011, alu_flags=5'b00100 -> next cycle flags=5'b00100 and EQ gives cond_ex=1.
- Conditional write that fails: flags=N=1 (5'b01000), cond=0101 (PL), flags_write=3'b011, alu_flags=5'b00110 -> cond_ex=0 and flags unchanged at 5'b01000.
- Q sticky: flags_write[2] with alu_flags[4]=1 -> Q=1. A later write with alu_flags[4]=0 -> Q stays 1. q_clear together with a Q set -> Q=1. q_clear alone -> Q=0.
- IT block: it_cond=0000, it_len=3, it_pattern=3'b101, Z=1 -> slots 0,1,2 give cond_ex=1,0,1 and it_remaining=3,2,1. Both stall cycles hold it_remaining. After the third advance, in_it=0.
- flush at slot 1 of a 4-long IT block -> next cycle in_it=0 and it_remaining=0, with no flag write from the flushed instruction. The following instruction uses its own cond.
- it_len=0 and it_len=5 (MAX=4) -> it_err one-cycle pulse and in_it=0. it_start while in_it=1 -> it_err pulse and it_remaining decrements by 1. cond=1111 -> cond_ex=0.
